// File: rtl/nh_pixel_streamer_pkg.sv
// Shared parameters, padded-geometry helpers and FSM encoding for the pixel streamer.
// NH_ZERO_PAD_EN widens the output frame by NH_DIM-1 in each dimension.
package nh_pixel_streamer_pkg;

   localparam int PIXEL_WIDTH = 8;
   localparam int IMG_WIDTH   = 28;
   localparam int IMG_HEIGHT  = 28;
   localparam int NH_DIM      = 3;
   localparam int ADDR_WIDTH  = 10;

   // Zero border thickness on each side of the emitted frame.
   function automatic int pad_of(input int nh_dim);
`ifdef NH_ZERO_PAD_EN
      return (nh_dim - 1) / 2;
`else
      return 0;
`endif
   endfunction

   // Emitted (padded) width or height for an image dimension.
   function automatic int out_dim(input int img_dim, input int nh_dim);
      return img_dim + 2 * pad_of(nh_dim);
   endfunction

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } stream_state_t;

   typedef struct packed {
      logic frame_end;
      logic line_end;
   } pix_tag_t;

endpackage

// File: rtl/nh_pixel_streamer_if.sv
// Control, RAM-read and shift-register handshake bundle of the pixel streamer.
interface nh_pixel_streamer_if #(
   parameter int PIXEL_WIDTH = nh_pixel_streamer_pkg::PIXEL_WIDTH,
   parameter int ADDR_WIDTH  = nh_pixel_streamer_pkg::ADDR_WIDTH
);
   logic                   start;
   logic                   stall;
   logic                   rd_en;
   logic [ADDR_WIDTH-1:0]  rd_addr;
   logic [PIXEL_WIDTH-1:0] rd_data;
   logic                   shift_out_rdy;
   logic [PIXEL_WIDTH-1:0] shift_out;
   logic                   line_end;
   logic                   frame_end;
   logic                   busy;
   logic                   done;

   modport master (
      input  start, stall, rd_data,
      output rd_en, rd_addr, shift_out_rdy, shift_out, line_end, frame_end, busy, done
   );

   modport slave (
      output start, stall, rd_data,
      input  rd_en, rd_addr, shift_out_rdy, shift_out, line_end, frame_end, busy, done
   );
endinterface

// File: rtl/nh_stream_skid_fifo.sv
// Two-entry skid FIFO of {frame_end, line_end, pixel}; an empty FIFO passes din
// straight to dout so a same-cycle push+pop costs no extra latency.
module nh_stream_skid_fifo
   import nh_pixel_streamer_pkg::*;
#(
   parameter int WIDTH = PIXEL_WIDTH + $bits(pix_tag_t)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic [1:0]       count
);
   logic [WIDTH-1:0] mem [2];
   logic             wr_ptr;
   logic             rd_ptr;
   logic             store;
   logic             drain;

   assign dout  = (count == 2'd0) ? din : mem[rd_ptr];
   assign store = push && !(pop && count == 2'd0);
   assign drain = pop && (count != 2'd0);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (store) wr_ptr <= ~wr_ptr;
         if (drain) rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, store} - {1'b0, drain};
      end
   end

   always_ff @(posedge clock) begin
      if (store) mem[wr_ptr] <= din;
   end
endmodule

// File: rtl/nh_pixel_streamer.sv
// Raster-order frame reader feeding the neighborhood shift-register controller.
// Build with NH_ZERO_PAD_EN to surround the frame with (NH_DIM-1)/2 zero pixels.
module nh_pixel_streamer
   import nh_pixel_streamer_pkg::*;
#(
   parameter int PIXEL_WIDTH = nh_pixel_streamer_pkg::PIXEL_WIDTH,
   parameter int IMG_WIDTH   = nh_pixel_streamer_pkg::IMG_WIDTH,
   parameter int IMG_HEIGHT  = nh_pixel_streamer_pkg::IMG_HEIGHT,
   parameter int NH_DIM      = nh_pixel_streamer_pkg::NH_DIM,
   parameter int ADDR_WIDTH  = nh_pixel_streamer_pkg::ADDR_WIDTH
) (
   input  logic                clock,
   input  logic                reset,
   nh_pixel_streamer_if.master bus
);
   localparam int OUT_W = out_dim(IMG_WIDTH, NH_DIM);
   localparam int OUT_H = out_dim(IMG_HEIGHT, NH_DIM);
   localparam int CW    = $clog2(OUT_W);
   localparam int RW    = $clog2(OUT_H);
   localparam int FW    = PIXEL_WIDTH + $bits(pix_tag_t);

   stream_state_t          state, state_nxt;
   logic [CW-1:0]          col;
   logic [RW-1:0]          row;
   logic [ADDR_WIDTH-1:0]  addr;
   logic                   last_col, last_row;
   logic                   issue, rd_en;
   logic                   pad_slot;

   logic                   fly_vld;
   pix_tag_t               fly_tag;
   logic [PIXEL_WIDTH-1:0] fly_pix;

   logic [1:0]             fifo_cnt;
   logic                   pop;
   logic [FW-1:0]          head;
   pix_tag_t               head_tag;

   logic                   out_rdy, out_le, out_fe;
   logic [PIXEL_WIDTH-1:0] out_pix;

   assign last_col = (col == CW'(OUT_W - 1));
   assign last_row = (row == RW'(OUT_H - 1));

`ifdef NH_ZERO_PAD_EN
   localparam int PAD = pad_of(NH_DIM);
   logic fly_pad;

   assign pad_slot = (col < CW'(PAD)) || (col >= CW'(IMG_WIDTH + PAD)) ||
                     (row < RW'(PAD)) || (row >= RW'(IMG_HEIGHT + PAD));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) fly_pad <= 1'b0;
      else        fly_pad <= pad_slot;
   end

   // Pad slots ride the same one-cycle slot as a real read, arriving as zero.
   assign fly_pix = fly_pad ? '0 : bus.rd_data;
`else
   assign pad_slot = 1'b0;
   assign fly_pix  = bus.rd_data;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // Issue only when a free FIFO entry is guaranteed for the returning slot.
   always_comb begin
      state_nxt = state;
      issue     = 1'b0;
      rd_en     = 1'b0;
      case (state)
         IDLE:  if (bus.start) state_nxt = RUN;
         RUN: begin
            issue = !bus.stall && (({1'b0, fifo_cnt} + {2'b0, fly_vld}) < 3'd2);
            rd_en = issue && !pad_slot;
            if (issue && last_col && last_row) state_nxt = DRAIN;
         end
         DRAIN: if (!fly_vld && fifo_cnt == 2'd0) state_nxt = DONE;
         DONE:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         col  <= '0;
         row  <= '0;
         addr <= '0;
      end else if (state == IDLE) begin
         col  <= '0;
         row  <= '0;
         addr <= '0;
      end else if (issue) begin
         if (rd_en) addr <= addr + 1'b1;
         if (last_col) begin
            col <= '0;
            row <= last_row ? '0 : row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         fly_vld <= 1'b0;
         fly_tag <= '0;
      end else begin
         fly_vld           <= issue;
         fly_tag.frame_end <= last_col && last_row;
         fly_tag.line_end  <= last_col;
      end
   end

   assign pop      = !bus.stall && (fifo_cnt != 2'd0 || fly_vld);
   assign head_tag = pix_tag_t'(head[FW-1:PIXEL_WIDTH]);

   nh_stream_skid_fifo #(.WIDTH(FW)) u_skid (
      .clock (clock),
      .reset (reset),
      .push  (fly_vld),
      .din   ({fly_tag, fly_pix}),
      .pop   (pop),
      .dout  (head),
      .count (fifo_cnt)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         out_rdy <= 1'b0;
         out_le  <= 1'b0;
         out_fe  <= 1'b0;
         out_pix <= '0;
      end else begin
         out_rdy <= pop;
         out_le  <= pop && head_tag.line_end;
         out_fe  <= pop && head_tag.frame_end;
         if (pop) out_pix <= head[PIXEL_WIDTH-1:0];
      end
   end

   assign bus.rd_en         = rd_en;
   assign bus.rd_addr       = addr;
   assign bus.shift_out_rdy = out_rdy;
   assign bus.shift_out     = out_pix;
   assign bus.line_end      = out_le;
   assign bus.frame_end     = out_fe;
   assign bus.busy          = (state != IDLE);
   assign bus.done          = (state == DONE);
endmodule

// File: tb/tb_nh_pixel_streamer.sv
// Self-checking bench for nh_pixel_streamer on a 4x3 image (padded 6x5 with NH_ZERO_PAD_EN).
module tb_nh_pixel_streamer;
   localparam int PW  = 8;
   localparam int W   = 4;
   localparam int H   = 3;
   localparam int NH  = 3;
   localparam int AW  = 10;
`ifdef NH_ZERO_PAD_EN
   localparam int P   = (NH - 1) / 2;
   localparam int OFS = 1;
`else
   localparam int P   = 0;
   localparam int OFS = 0;
`endif
   localparam int OW   = W + 2 * P;
   localparam int OH   = H + 2 * P;
   localparam int NOUT = OW * OH;
   localparam int NPIX = W * H;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   nh_pixel_streamer_if #(.PIXEL_WIDTH(PW), .ADDR_WIDTH(AW)) intf ();

   nh_pixel_streamer #(
      .PIXEL_WIDTH(PW), .IMG_WIDTH(W), .IMG_HEIGHT(H), .NH_DIM(NH), .ADDR_WIDTH(AW)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (intf)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   logic [PW-1:0] ram [0:(1<<AW)-1];
   logic [PW-1:0] s_pix[$];
   bit            s_le[$];
   bit            s_fe[$];
   int            s_cyc[$];
   int            done_q[$];
   int            rd_addr_q[$];
   int            rd_stalled;
   int            stall_strobe;
   int            rd_first;

   always @(posedge clock) cyc <= cyc + 1;

   // RAM model: one-cycle read latency; also logs the read stream.
   always @(posedge clock) begin
      if (intf.rd_en) begin
         intf.rd_data <= ram[intf.rd_addr];
         rd_addr_q.push_back(int'(intf.rd_addr));
         if (intf.stall) rd_stalled++;
         if (rd_first < 0) rd_first = cyc;
      end
   end

   // Output monitor, sampled just after the edge.
   always @(posedge clock) begin
      #1;
      if (intf.shift_out_rdy) begin
         s_pix.push_back(intf.shift_out);
         s_le.push_back(intf.line_end);
         s_fe.push_back(intf.frame_end);
         s_cyc.push_back(cyc);
         if (intf.stall) stall_strobe++;
      end
      if (intf.done) done_q.push_back(cyc);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic clear_logs();
      s_pix.delete(); s_le.delete(); s_fe.delete(); s_cyc.delete();
      done_q.delete(); rd_addr_q.delete();
      rd_stalled = 0; stall_strobe = 0; rd_first = -1;
   endtask

   // mode: 0 no stall, 1 stall in cycles 5..9, 2 toggle, 3 random. extra: spurious starts.
   task automatic run_frame(input string nm, input int mode, input bit extra, output int t0);
      bit fin;
      int after;
      int rel;
      clear_logs();
      @(negedge clock);
      intf.start = 1'b1;
      t0 = cyc;
      fin = 1'b0;
      after = 0;
      for (int k = 0; k < 3000 && after < 8; k++) begin
         @(negedge clock);
         rel = cyc - t0;
         intf.start = 1'b0;
         case (mode)
            1:       intf.stall = (rel >= 5 && rel <= 9);
            2:       intf.stall = rel[0];
            3:       intf.stall = ($urandom_range(0, 2) == 0);
            default: intf.stall = 1'b0;
         endcase
         if (extra && (rel == 6 || intf.done)) intf.start = 1'b1;
         if (intf.done) fin = 1'b1;
         if (fin) begin
            after++;
            intf.stall = 1'b0;
         end
      end
      if (!fin) check({nm, "_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic check_frame(input string nm, input int t0, input bit timing);
      int r, c, last;
      logic [PW-1:0] ev;
      bit ele, efe;
      check({nm, "_strobes"}, 32'(s_pix.size()), 32'(NOUT));
      for (int i = 0; i < s_pix.size() && i < NOUT; i++) begin
         r = i / OW;
         c = i % OW;
         if (r >= P && r < H + P && c >= P && c < W + P) ev = ram[(r - P) * W + (c - P)];
         else ev = '0;
         ele = (c == OW - 1);
         efe = ele && (r == OH - 1);
         check({nm, "_pix"}, 32'({s_le[i], s_fe[i], s_pix[i]}), 32'({ele, efe, ev}));
      end
      check({nm, "_reads"}, 32'(rd_addr_q.size()), 32'(NPIX));
      for (int i = 0; i < rd_addr_q.size() && i < NPIX; i++)
         check({nm, "_rdaddr"}, 32'(rd_addr_q[i]), 32'(i));
      check({nm, "_rd_in_stall"}, 32'(rd_stalled), 32'd0);
      check({nm, "_strobe_after_stall"}, 32'(stall_strobe), 32'd0);
      check({nm, "_done_pulses"}, 32'(done_q.size()), 32'd1);
      last = s_cyc.size() - 1;
      if (done_q.size() > 0 && last >= 0)
         check({nm, "_done_cycle"}, 32'(done_q[0]), 32'(s_cyc[last] + 1));
      check({nm, "_busy_after"}, 32'(intf.busy), 32'd0);
      if (timing && last >= 0) begin
         check({nm, "_first_rd"}, 32'(rd_first), 32'(t0 + 1 + P * OW + P));
         check({nm, "_first_strobe"}, 32'(s_cyc[0]), 32'(t0 + 3));
         check({nm, "_gapfree"}, 32'(s_cyc[last] - s_cyc[0]), 32'(NOUT - 1));
      end
   endtask

   int t0;

   initial begin
      intf.start = 1'b0;
      intf.stall = 1'b0;
      rd_first   = -1;
      for (int a = 0; a < (1 << AW); a++) ram[a] = PW'(a + OFS);

      repeat (3) @(negedge clock);
      check("rst_rd_en",   32'(intf.rd_en), 32'd0);
      check("rst_rd_addr", 32'(intf.rd_addr), 32'd0);
      check("rst_outs",    32'({intf.shift_out_rdy, intf.line_end, intf.frame_end, intf.shift_out}), 32'd0);
      check("rst_busy_done", 32'({intf.busy, intf.done}), 32'd0);
      reset = 1'b1;

      run_frame("basic", 0, 1'b0, t0);
      check_frame("basic", t0, 1'b1);

      run_frame("stallwin", 1, 1'b0, t0);
      check_frame("stallwin", t0, 1'b0);

      run_frame("toggle", 2, 1'b0, t0);
      check_frame("toggle", t0, 1'b0);

      run_frame("xstart", 0, 1'b1, t0);
      check_frame("xstart", t0, 1'b1);
      run_frame("second", 0, 1'b0, t0);
      check_frame("second", t0, 1'b1);

      // Abort on the fifth strobe.
      clear_logs();
      @(negedge clock);
      intf.start = 1'b1;
      @(negedge clock);
      intf.start = 1'b0;
      for (int n = 0; n < 100 && s_pix.size() < 5; n++) @(negedge clock);
      check("abort_reach5", 32'(s_pix.size()), 32'd5);
      reset = 1'b0;
      #1;
      check("abort_outs", 32'({intf.shift_out_rdy, intf.line_end, intf.frame_end, intf.shift_out}), 32'd0);
      check("abort_ctl",  32'({intf.busy, intf.done, intf.rd_en}), 32'd0);
      repeat (2) @(negedge clock);
      reset = 1'b1;
      repeat (6) @(negedge clock);
      check("abort_no_more", 32'(s_pix.size()), 32'd5);
      check("abort_idle", 32'(intf.busy), 32'd0);
      run_frame("after_rst", 0, 1'b0, t0);
      check_frame("after_rst", t0, 1'b1);

      for (int f = 0; f < 2; f++) begin
         for (int a = 0; a < NPIX; a++) ram[a] = PW'($urandom_range(0, 255));
         run_frame("random", 3, 1'b0, t0);
         check_frame("random", t0, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/nh_pixel_streamer.md
Name: nh_pixel_streamer

Overview:
- Transmit side of the neighborhood shift-register pixel interface.
- Reads one image frame from a single-port image RAM in raster order (row 0 col 0 first).
- Drives the `shift_in` / `shift_in_rdy` pair of the neighborhood shift-register controller: one pixel per strobe.
- Supports downstream stall and optional zero-padded borders so windows can centre on edge pixels.

Parameters:
- PIXEL_WIDTH, 8, bits per pixel.
- IMG_WIDTH, 28, pixels per image row.
- IMG_HEIGHT, 28, rows per frame.
- NH_DIM, 3, neighborhood side length; odd, ≥ 3.
- ADDR_WIDTH, 10, RAM address width; must satisfy 2^ADDR_WIDTH ≥ IMG_WIDTH*IMG_HEIGHT.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low.
- start  in  1  one-cycle pulse; begins a frame when idle, ignored otherwise.
- stall  in  1  downstream cannot accept a pixel this cycle.
- rd_en  out  1  RAM read enable.
- rd_addr  out  ADDR_WIDTH  RAM address = row*IMG_WIDTH+col.
- rd_data  in  PIXEL_WIDTH  RAM data, valid exactly 1 cycle after rd_en.
- shift_out_rdy  out  1  one-cycle strobe: shift_out carries a valid pixel.
- shift_out  out  PIXEL_WIDTH  pixel value.
- line_end  out  1  qualifies the last pixel of an output row (with shift_out_rdy).
- frame_end  out  1  qualifies the last pixel of the frame (with shift_out_rdy).
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse after the last pixel strobe.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters 0, skid buffer empty.
- Reset mid-frame aborts the frame; no further strobes are issued.
- FSM states:
  - IDLE: on start go to RUN, set busy.
  - RUN: issue reads (and pad slots, if enabled) in raster order. After the last slot is issued, go to DRAIN.
  - DRAIN: wait for the in-flight read and skid buffer to empty and the last strobe to go out, then go to DONE.
  - DONE: pulse done, clear busy, return to IDLE.
- Read issue:
  - A slot is issued in a cycle when stall==0 and (skid occupancy + reads in flight) < 2.
  - Slot counters (col, row) advance only on issue.
  - col wraps to 0 at width-1 and row increments.
- Data path:
  - Returning rd_data enters a 2-entry FIFO skid buffer.
  - Each cycle with stall==0 and the buffer non-empty, the head is popped into the output register.
  - shift_out_rdy=1 on the next cycle; otherwise shift_out_rdy=0 and shift_out holds its last value.
- Latency, no stall: start at cycle 0 → rd_en at cycle 1 → first shift_out_rdy at cycle 3. Throughput is 1 pixel/cycle thereafter.
- Stall: at most 2 pixels are buffered, none lost, none duplicated, order preserved. When stall is held, rd_en deasserts within 1 cycle.
- line_end and frame_end travel in the skid buffer with their pixel. frame_end implies line_end.
- start while busy: ignored.
- start in the same cycle as the DONE→IDLE transition: ignored. A new frame needs start while busy==0.
- Unpadded output: IMG_WIDTH*IMG_HEIGHT strobes; rd_addr increments by exactly 1 per issue.

Optional Feature:
- Macro: NH_ZERO_PAD_EN.
- Defined:
  - Output frame is (IMG_WIDTH+NH_DIM-1) × (IMG_HEIGHT+NH_DIM-1), with P=(NH_DIM-1)/2 zero pixels on every border.
  - Pad slots do not assert rd_en. They enter the skid buffer as zero with the same 2-cycle latency and obey the same stall rules.
  - line_end and frame_end refer to padded geometry.
- Undefined: no pad logic is compiled; behaviour is as above.

Decomposition:
- Shared network parameter package holds:
  - PIXEL_WIDTH, NH_DIM, IMG_WIDTH, IMG_HEIGHT;
  - derived padded width/height;
  - address width;
  - FSM state encoding (IDLE, RUN, DRAIN, DONE).
- One sub-module: nh_stream_skid_fifo, a 2-entry FIFO of {frame_end, line_end, pixel} with push, pop, occupancy count.

Test Plan:
- Basic frame, IMG 4×3, RAM[a]=a, stall=0:
  - rd_en at cycle 1, first strobe at cycle 3 with value 0;
  - 12 consecutive strobes, values 0..11;
  - line_end on values 3, 7, 11; frame_end on 11;
  - done 1 cycle after the last strobe.
- Stall mid-frame: stall=1 for cycles 5–9 then 0:
  - no strobes while stalled, at most 2 buffered;
  - stream resumes gap-free with no missing or duplicated values; total count is 12.
- Stall toggled every cycle throughout: output sequence still 0..11 in order; strobes only in cycles following stall==0.
- start pulsed while busy and in the DONE cycle: ignored; exactly one frame is emitted. A subsequent start while idle produces a second identical frame.
- Reset asserted at the 5th strobe: all outputs 0 immediately, busy=0. A new start gives a full frame from value 0.
- NH_ZERO_PAD_EN, NH_DIM=3, IMG 4×3, RAM[a]=a+1:
  - 6×5=30 strobes; rows 0 and 4 all zero; columns 0 and 5 zero;
  - interior row 1 reads 0,1,2,3,4,0;
  - exactly 12 rd_en pulses.
